sym_seq_gen: RTL and testbench

// - Moore-style 2-bit symbol sequence generator. Transmit-side counterpart of the
//   lab2 Moore sequence detector: it produces the symbol stream `a` that the detector consumes.
// - Plays a fixed pattern COUNT times with a valid/ready handshake and optional inter-pattern gaps.
// - Sits in front of the detector in the lab2 top, replacing the bench-driven `a` stimulus.

---
 rtl/lab2_pkg.sv | 9 +
 rtl/sym_seq_gen.sv | 126 ++++++++++++
 tb/tb_sym_seq_gen.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lab2_pkg.sv
// Shared types for the lab2 symbol generator and detector pair.
package lab2_pkg;

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} gen_state_t;
    typedef logic [1:0] sym_t;

    localparam sym_t SYM_IDLE = 2'b00;

endpackage

// File: rtl/sym_seq_gen.sv
// Moore 2-bit symbol sequence generator: plays PATTERN count times over a valid/ready link.
// Define SYM_SEQ_GEN_LOOP_EN for the `stop` input and loop-forever mode when count==0.
module sym_seq_gen
    import lab2_pkg::*;
#(
    parameter int                     PAT_LEN    = 4,
    parameter logic [2*PAT_LEN-1:0]   PATTERN    = 8'b00101101,
    parameter int                     GAP_CYCLES = 0,
    parameter int                     CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             ready,
`ifdef SYM_SEQ_GEN_LOOP_EN
    input  logic             stop,
`endif
    output logic [1:0]       a,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    gen_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             stop_q, stop_d;
    logic             stop_req;
    logic             last_rep;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rep_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            stop_q  <= stop_d;
        end
    end

    // cnt_q==0 only survives into SEND in loop mode, where it means "never last".
    assign last_rep = (cnt_q != '0) && (rep_q == cnt_q - CNT_W'(1));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rep_d    = rep_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        stop_d   = stop_q;
`ifdef SYM_SEQ_GEN_LOOP_EN
        stop_req = stop_q || stop;
        if (state_q == SEND || state_q == GAP) stop_d = stop_req;
`else
        stop_req = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d  = '0;
                    rep_d  = '0;
                    gap_d  = '0;
                    cnt_d  = count;
                    stop_d = 1'b0;
`ifdef SYM_SEQ_GEN_LOOP_EN
                    state_d = SEND;
`else
                    state_d = (count != '0) ? SEND : DONE;
`endif
                end
            end
            SEND: begin
                if (ready) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        if (last_rep || stop_req) begin
                            state_d = DONE;
                        end else begin
                            if (cnt_q != '0) rep_d = rep_q + CNT_W'(1);
                            if (GAP_CYCLES > 0) begin
                                state_d = GAP;
                                gap_d   = '0;
                            end
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = SEND;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid = (state_q == SEND);
        busy  = (state_q == SEND) || (state_q == GAP);
        done  = (state_q == DONE);
        a     = valid ? PATTERN[{idx_q, 1'b0} +: 2] : SYM_IDLE;
    end

endmodule

// File: tb/tb_sym_seq_gen.sv
// Scoreboard bench for sym_seq_gen: default instance plus a GAP_CYCLES=2 instance.
module tb_sym_seq_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, ready, stop;
    logic [3:0] count;
    logic [1:0] a;
    logic       valid, busy, done;

    logic       start_g, ready_g, stop_g;
    logic [3:0] count_g;
    logic [1:0] a_g;
    logic       valid_g, busy_g, done_g;

    int total = 0;
    int bad   = 0;

    // {done, a} per transfer or done pulse on the default instance
    logic [2:0] sb_main[$];
    // {busy, valid, done, a} per active cycle on the gap instance
    logic [4:0] sb_gap[$];

    always #5 clk = ~clk;

    sym_seq_gen dut (
        .clk(clk), .rst(rst), .start(start), .count(count), .ready(ready),
`ifdef SYM_SEQ_GEN_LOOP_EN
        .stop(stop),
`endif
        .a(a), .valid(valid), .busy(busy), .done(done)
    );

    sym_seq_gen #(.GAP_CYCLES(2)) dut_g (
        .clk(clk), .rst(rst), .start(start_g), .count(count_g), .ready(ready_g),
`ifdef SYM_SEQ_GEN_LOOP_EN
        .stop(stop_g),
`endif
        .a(a_g), .valid(valid_g), .busy(busy_g), .done(done_g)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if ((valid && ready) || done) begin
                if (sb_main.size() == 0) chk("main_unexpected", {5'b0, done, a}, 8'hff);
                else chk("main_stream", {5'b0, done, a}, {5'b0, sb_main.pop_front()});
            end
            if (!valid) chk("main_idle_sym", {6'b0, a}, 8'h00);
        end
    end

    always @(negedge clk) begin
        if (!rst && (busy_g || done_g)) begin
            if (sb_gap.size() == 0) chk("gap_unexpected", {3'b0, busy_g, valid_g, done_g, a_g}, 8'hff);
            else chk("gap_stream", {3'b0, busy_g, valid_g, done_g, a_g}, {3'b0, sb_gap.pop_front()});
        end
    end

    task automatic push_pattern();
        sb_main.push_back(3'b001);
        sb_main.push_back(3'b011);
        sb_main.push_back(3'b010);
        sb_main.push_back(3'b000);
    endtask

    task automatic push_gap_pattern();
        sb_gap.push_back(5'b11001);
        sb_gap.push_back(5'b11011);
        sb_gap.push_back(5'b11010);
        sb_gap.push_back(5'b11000);
    endtask

    // start is asserted at posedge+1 and sampled on the following edge
    task automatic start_main(input logic [3:0] c);
        count = c;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drain_main(input string name);
        int n = 0;
        while (sb_main.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_drain"}, 8'(sb_main.size()), 8'h00);
        @(posedge clk); #1;
        chk({name, "_end"}, {5'b0, busy, valid, done}, 8'h00);
    endtask

    task automatic wait_sym(input logic [1:0] s, input string name);
        int n = 0;
        while (!(valid && a == s) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_found"}, {6'b0, valid, (a == s)}, 8'h03);
    endtask

    initial begin
        rst = 1'b1; start = 0; count = 0; ready = 1; stop = 0;
        start_g = 0; count_g = 0; ready_g = 1; stop_g = 0;
        #1;
        chk("reset_outputs", {4'b0, a, valid, busy}, 8'h00);
        chk("reset_done", {7'b0, done}, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // single run
        push_pattern();
        sb_main.push_back(3'b100);
        start_main(4'd1);
        chk("single_latency", {5'b0, valid, a}, 8'h05);
        drain_main("single");

        // backpressure on symbol 11
        push_pattern();
        sb_main.push_back(3'b100);
        start_main(4'd1);
        wait_sym(2'b11, "bp");
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold", {5'b0, valid, a}, 8'h07);
            chk("bp_busy", {7'b0, busy}, 8'h01);
            if (i < 2) begin
                @(posedge clk); #1;
            end
        end
        ready = 1'b1;
        drain_main("bp");

        // two back-to-back patterns, no bubble
        push_pattern();
        push_pattern();
        sb_main.push_back(3'b100);
        start_main(4'd2);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
        end
        chk("b2b_second_last", {5'b0, valid, a}, 8'h04);
        drain_main("b2b");

        // start while busy is ignored
        push_pattern();
        sb_main.push_back(3'b100);
        start_main(4'd1);
        start = 1'b1; count = 4'd3;
        @(posedge clk); #1;
        start = 1'b0;
        drain_main("start_ignored");

`ifndef SYM_SEQ_GEN_LOOP_EN
        // zero count goes straight to done
        sb_main.push_back(3'b100);
        start_main(4'd0);
        chk("zero_done", {5'b0, valid, busy, done}, 8'h01);
        drain_main("zero");
`endif

        // reset mid-SEND at idx 2
        push_pattern();
        sb_main.push_back(3'b100);
        start_main(4'd1);
        wait_sym(2'b10, "rst_mid");
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs", {4'b0, a, valid, busy}, 8'h00);
        chk("rst_mid_done", {7'b0, done}, 8'h00);
        sb_main.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        push_pattern();
        sb_main.push_back(3'b100);
        start_main(4'd1);
        chk("rst_restart", {5'b0, valid, a}, 8'h05);
        drain_main("rst_restart");

        // gap instance: two patterns separated by two idle cycles
        push_gap_pattern();
        sb_gap.push_back(5'b10000);
        sb_gap.push_back(5'b10000);
        push_gap_pattern();
        sb_gap.push_back(5'b00100);
        count_g = 4'd2;
        start_g = 1'b1;
        @(posedge clk); #1;
        start_g = 1'b0;
        chk("gap_latency", {5'b0, valid_g, a_g}, 8'h05);
        for (int n = 0; n < 40 && sb_gap.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        chk("gap_drain", 8'(sb_gap.size()), 8'h00);
        @(posedge clk); #1;
        chk("gap_end", {5'b0, busy_g, valid_g, done_g}, 8'h00);

`ifdef SYM_SEQ_GEN_LOOP_EN
        // loop forever, stopped during third 10 symbol
        begin
            int hits = 0;
            int n = 0;
            for (int p = 0; p < 3; p++) push_pattern();
            sb_main.push_back(3'b100);
            start_main(4'd0);
            while (hits < 3 && n < 100) begin
                if (valid && a == 2'b10) hits++;
                if (hits < 3) begin
                    @(posedge clk); #1;
                end
                n++;
            end
            chk("loop_hits", 8'(hits), 8'd3);
            stop = 1'b1;
            @(posedge clk); #1;
            stop = 1'b0;
            drain_main("loop");
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
